mul8s_rr_sched: RTL and testbench
=================================

Name: mul8s_rr_sched

Overview:
- Shares one combinational signed 8x8 multiply datapath among NREQ requesters.
- Round-robin arbitration selects one requester per cycle. Operands pass through a 2-stage valid/ready pipeline.
- Each result returns tagged with the requester ID.
- Sits between the lab's compute clients and the multiplier. Provides full throughput of 1 product/cycle with backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), derived localparam: requester ID width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  8*NREQ  signed multiplicand, requester i at [8i+7:8i]
- req_b  in  8*NREQ  signed multiplier, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  requester index of result
- rsp_y  out  16  signed product a*b
- op_count  out  16  results delivered (rsp_valid&&rsp_ready), wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_id=0, rsp_y=0, op_count=0, rr pointer=0. req_ready=0 while in reset.
- Arbitration (combinational):
  - Priority order is ptr, ptr+1, ..., ptr+NREQ-1 mod NREQ. First asserted req_valid wins.
  - req_ready[win] = s1_free; all other bits 0.
  - s1_free = !s1_valid || s2_free.
  - s2_free = !s2_valid || rsp_ready.
- Pointer: on accept of requester i, ptr <= (i+1) mod NREQ. No accept -> ptr holds.
- Requester rule: valid and operands held stable until accepted. Block does not check this.
- Stage 1: on accept at edge E, latch a, b, id; s1_valid=1.
- Stage 2: at edge E+1 (if s2_free), latch s2_y = sign-extended a * sign-extended b (16-bit two's complement), s2_id; s2_valid=1.
- Outputs: rsp_valid=s2_valid, rsp_y=s2_y, rsp_id=s2_id. All driven from registers.
- Latency: accept edge E -> rsp_valid high after E+1 (2 edges) when unstalled.
- Throughput: one accept per cycle when rsp_ready=1 continuously.
- Stall: rsp_valid && !rsp_ready holds s2 (rsp_y/rsp_id stable). s1 then holds if valid; no new accept while s1 is full. No data loss or duplication.
- Simultaneous: s2 drains and s1 advances and new accept in the same edge is legal (full pipeline flow).
- Empty s1 with stalled s2: s1 may still accept one entry (s1_free=1).
- Range: full range is exact, including -128*-128=+16384, -128*127=-16256, x*0=0.
- op_count increments on each rsp_valid&&rsp_ready edge, wraps modulo 2^16.
- Reset mid-operation: both stages flushed asynchronously; in-flight results discarded; ptr=0. First accept after deassert is the lowest-index valid requester.

Decomposition:
- Shared package mul_sched_pkg:
  - MUL_W=8, PROD_W=16 constants.
  - typedef mul_req_t {a, b, id}.
  - typedef mul_rsp_t {y, id}.
- Sub-module rr_arbiter (parameter NREQ): inputs req, ptr, en; outputs one-hot grant and encoded index. Pointer register lives in the top.
- Multiply is an inline signed expression in stage 2; no separate module.

Test Plan:
- Single request: req_valid=0001, a=5, b=-3, rsp_ready=1 -> req_ready=0001 at cycle 0; rsp_valid two edges later with rsp_y=-15 (0xFFF1), rsp_id=0; op_count=1.
- Extremes, one per cycle from requester 2: (-128,-128), (-128,127), (127,127), (0,-77) -> rsp_y 16384, -16256, 16129, 0 in order, consecutive cycles, rsp_id=2.
- All four requesters valid continuously with distinct operands, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches; no requester starved; 1 result/cycle.
- Backpressure: pipeline full, rsp_ready=0 for 3 cycles -> rsp_y/rsp_id stable; req_ready=0 all bits; after release, results resume in order with no loss or duplicates.
- Reset mid-flight: assert rst_n=0 with both stages valid -> rsp_valid drops immediately (async), op_count=0. After release, requesters 3 and 1 valid -> requester 1 granted first.
- op_count wrap: preload via 65535 deliveries (or force), one more handshake -> op_count=0.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and widths for the round-robin scheduled signed 8x8 multiplier.
package mul_sched_pkg;

  localparam int MUL_W    = 8;
  localparam int PROD_W   = 16;
  // Widest requester ID across the supported NREQ range (2..8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic signed [MUL_W-1:0] a;
    logic signed [MUL_W-1:0] b;
    logic [ID_MAX_W-1:0]     id;
  } mul_req_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] y;
    logic [ID_MAX_W-1:0]      id;
  } mul_rsp_t;

endpackage

// File: rtl/mul8s_rr_sched_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    // Grant is withheld when stage 1 cannot take an entry, but the winner index stays valid.
    if (any_o && en_i) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mul8s_rr_sched.sv
// NREQ requesters share one signed 8x8 multiply through a two-stage valid/ready pipeline.
module mul8s_rr_sched
  import mul_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [MUL_W*NREQ-1:0]   req_a,
  input  logic [MUL_W*NREQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [PROD_W-1:0]       rsp_y,
  output logic [15:0]             op_count
);

  mul_req_t        s1_q, s1_d;
  mul_rsp_t        s2_q, s2_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     op_cnt_q, op_cnt_d;

  logic            s1_free, s2_free;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic            accept;
  logic [MUL_W-1:0] sel_a, sel_b;
  logic signed [PROD_W-1:0] a_x, b_x, prod;
  logic            unused_id_hi;

  assign s2_free = !s2_valid_q || rsp_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // rst_n gates the grant so req_ready stays low throughout reset.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (rst_n && s1_free),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_a = req_a[i*MUL_W +: MUL_W];
        sel_b = req_b[i*MUL_W +: MUL_W];
      end
    end
  end

  assign a_x  = {{(PROD_W-MUL_W){s1_q.a[MUL_W-1]}}, s1_q.a};
  assign b_x  = {{(PROD_W-MUL_W){s1_q.b[MUL_W-1]}}, s1_q.b};
  assign prod = a_x * b_x;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    ptr_d      = ptr_q;
    op_cnt_d   = op_cnt_q;

    // A new accept always refills s1; otherwise s1 empties only if it moved into s2.
    if (accept) begin
      s1_d       = '{a: sel_a, b: sel_b, id: ID_MAX_W'(win_idx)};
      s1_valid_d = 1'b1;
    end else if (s2_free) begin
      s1_valid_d = 1'b0;
    end

    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = '{y: prod, id: s1_q.id};
    end

    if (accept) ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;

    if (s2_valid_q && rsp_ready) op_cnt_d = op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
      ptr_q      <= '0;
      op_cnt_q   <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
      ptr_q      <= ptr_d;
      op_cnt_q   <= op_cnt_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_y     = s2_q.y;
  assign rsp_id    = IDW'(s2_q.id);
  assign op_count  = op_cnt_q;

  // Upper ID bits only matter for larger NREQ; fold them so they count as consumed.
  assign unused_id_hi = ^{s2_q.id, win_any};

endmodule

// File: tb/tb_mul8s_rr_sched.sv
// Directed bench for mul8s_rr_sched with a result scoreboard fed at accept time.
module tb_mul8s_rr_sched;

  localparam int NREQ = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [31:0]   req_a, req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_y;
  logic [15:0]   op_count;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] y;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul8s_rr_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  // Runs at the falling edge: record accepts about to happen, retire handshakes about to happen.
  task automatic monitor();
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      chk("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
      if (rsp_valid && rsp_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_rsp_y", 32'(rsp_y), 32'(e.y));
          chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = 2'(i);
          e.y  = ref_mul(req_a[8*i +: 8], req_b[8*i +: 8]);
          sb.push_back(e);
        end
      end
    end
  endtask

  // One clock: monitor at negedge, then return at posedge+1 with fresh operands for accepted requesters.
  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) set_ops(i, 8'($urandom), 8'($urandom));
  endtask

  task automatic drain();
    int n;
    req_valid = 4'b0000;
    n = 0;
    while (!(rsp_valid == 1'b0 && sb.size() == 0) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [7:0]  ea[4];
  logic [7:0]  eb[4];
  logic [15:0] ey[4];
  logic [3:0]  rr_rdy[8];
  logic [1:0]  rr_id[8];

  initial begin
    int n;
    ea = '{8'h80, 8'h80, 8'h7F, 8'h00};
    eb = '{8'h80, 8'h7F, 8'h7F, 8'hB3};
    ey = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000};
    rr_rdy = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    rr_id  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;

    // Reset state
    #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    req_valid = 4'b0000;
    rst_n     = 1'b1;

    // Single request 5 * -3
    set_ops(0, 8'd5, 8'hFD);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 4'b0000;
    chk("single_lat_e", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_y", 32'(rsp_y), 32'h0000FFF1);
    chk("single_id", 32'(rsp_id), 32'd0);
    tick();
    chk("single_op_count", 32'(op_count), 32'd1);
    chk("single_done", 32'(rsp_valid), 32'd0);

    // Range extremes from requester 2, back to back
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        set_ops(2, ea[k], eb[k]);
        req_valid = 4'b0100;
        #1;
        chk("ext_ready", 32'(req_ready), 32'd4);
      end else begin
        req_valid = 4'b0000;
      end
      tick();
      if (k >= 1 && k <= 4) begin
        chk("ext_valid", 32'(rsp_valid), 32'd1);
        chk("ext_y", 32'(rsp_y), 32'(ey[k-1]));
        chk("ext_id", 32'(rsp_id), 32'd2);
      end
    end
    drain();

    // All four requesters continuously valid; pointer sits at 3 after the extremes
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(rr_rdy[k]));
      tick();
      if (k >= 1) begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id", 32'(rsp_id), 32'(rr_id[k-1]));
      end
    end
    drain();

    // Backpressure with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    #1;
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    chk("bp_full_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_y", 32'(rsp_y), 32'(sb[0].y));
      chk("bp_hold_id", 32'(rsp_id), 32'(sb[0].id));
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    repeat (4) tick();
    drain();

    // Reset with both stages occupied
    req_valid = 4'b1111;
    repeat (3) tick();
    rsp_ready = 1'b0;
    tick();
    chk("rm_pre_valid", 32'(rsp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", 32'(rsp_valid), 32'd0);
    chk("rm_op_count", 32'(op_count), 32'd0);
    chk("rm_req_ready", 32'(req_ready), 32'd0);
    chk("rm_rsp_y", 32'(rsp_y), 32'd0);
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    rst_n     = 1'b1;
    #1;
    chk("rm_first_grant", 32'(req_ready), 32'd2);
    tick();
    chk("rm_second_grant", 32'(req_ready), 32'd8);
    drain();
    chk("rm_op_count_after", 32'(op_count), 32'd1);

    // op_count wrap through continuous flow from requester 0
    req_valid = 4'b0001;
    n = 0;
    while (op_count !== 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    chk("wrap_reached", 32'(op_count), 32'h0000FFFF);
    chk("wrap_valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("wrap_zero", 32'(op_count), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
